// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: one state per cycle, memory handshake on
// mem_ready, and a wrapping counter of retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StJal     = 4'd9,
        StJalr    = 4'd10
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    state_e           state_q, state_d;
    logic [6:0]       opc_q;
    logic [CNT_W-1:0] instret_q;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state_d    = state_q;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // ALUOut <- oldPC + imm, the branch/jal target
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (opcode)
                    OpR, OpI:        state_d = StExec;
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = (opc_q == OpStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExec: begin
                alu_src_a = 2'b10;
                alu_src_b = (opc_q == OpR) ? 2'b00 : 2'b10;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = br_taken;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC already holds oldPC+4, so it is the link value
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset silences every strobe and select so an abandoned access has no effect
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            opc_q     <= 7'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) opc_q <= opcode;
            if (instr_done) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
